// File: rtl/confreg_responder.sv
// Memory-mapped config/peripheral registers on the data SRAM bus.
// Scratch, LED, switch, timer, 7-seg and UART TX FIFO with SRAM-like timing.
module confreg_responder #(
    parameter logic [15:0] BASE_HI    = 16'hbfaf,
    parameter int          UART_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready
);
    localparam int PW = $clog2(UART_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [13:0] O_S0   = 14'h00;
    localparam logic [13:0] O_S1   = 14'h01;
    localparam logic [13:0] O_LED  = 14'h04;
    localparam logic [13:0] O_SW   = 14'h05;
    localparam logic [13:0] O_TIM  = 14'h08;
    localparam logic [13:0] O_TCMP = 14'h09;
    localparam logic [13:0] O_TCTL = 14'h0a;
    localparam logic [13:0] O_UD   = 14'h0c;
    localparam logic [13:0] O_US   = 14'h0d;
    localparam logic [13:0] O_NUM  = 14'h10;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    logic [31:0] scratch0, scratch1, timer, tcmp, num;
    logic [15:0] led_q;
    logic        t_en, t_irq_en, pend, ovf;
    logic [7:0]  sw_s1, sw_s2;
    logic [7:0]  mem [UART_DEPTH];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] cnt;

    logic        hit, wr, rd;
    logic [13:0] off;
    logic [31:0] rsel, led_m;
    logic        full, empty, pop, push_req, push_ok, pend_set;
    logic [3:0]  cnt4;
    logic        unused_bits;

    assign unused_bits = ^data_sram_addr[1:0];

    assign off = data_sram_addr[15:2];
    assign hit = data_sram_en & (data_sram_addr[31:16] == BASE_HI);
    assign wr  = hit & (|data_sram_we);
    assign rd  = hit & (data_sram_we == 4'b0);

    assign led_m = merge({16'b0, led_q}, data_sram_wdata, data_sram_we);

    assign full     = (cnt == CW'(UART_DEPTH));
    assign empty    = (cnt == '0);
    assign cnt4     = 4'(cnt);
    assign pop      = uart_tx_valid & uart_tx_ready;
    assign push_req = wr & (off == O_UD) & data_sram_we[0];
    // A push into a full FIFO still lands if the head leaves this cycle
    assign push_ok  = push_req & (~full | pop);
    assign pend_set = t_en & (timer == tcmp);

    assign led           = led_q;
    assign num_data      = num;
    assign timer_irq     = pend & t_irq_en;
    assign uart_tx_valid = ~empty;
    assign uart_tx_data  = mem[rp];

    always_comb begin
        rsel = '0;
        case (off)
            O_S0:   rsel = scratch0;
            O_S1:   rsel = scratch1;
            O_LED:  rsel = {16'b0, led_q};
            O_SW:   rsel = {24'b0, sw_s2};
            O_TIM:  rsel = timer;
            O_TCMP: rsel = tcmp;
            O_TCTL: rsel = {29'b0, pend, t_irq_en, t_en};
            O_US:   rsel = {24'b0, cnt4, 1'b0, ovf, empty, full};
            O_NUM:  rsel = num;
            default: rsel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch0        <= '0;
            scratch1        <= '0;
            led_q           <= '0;
            timer           <= '0;
            tcmp            <= '0;
            num             <= '0;
            t_en            <= 1'b0;
            t_irq_en        <= 1'b0;
            pend            <= 1'b0;
            data_sram_rdata <= '0;
            sw_s1           <= '0;
            sw_s2           <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
            if (data_sram_en & ~hit)
                data_sram_rdata <= '0;
            else if (rd)
                data_sram_rdata <= rsel;
            if (wr & (off == O_S0))
                scratch0 <= merge(scratch0, data_sram_wdata, data_sram_we);
            if (wr & (off == O_S1))
                scratch1 <= merge(scratch1, data_sram_wdata, data_sram_we);
            if (wr & (off == O_LED))
                led_q <= led_m[15:0];
            if (wr & (off == O_TCMP))
                tcmp <= merge(tcmp, data_sram_wdata, data_sram_we);
            if (wr & (off == O_NUM))
                num <= merge(num, data_sram_wdata, data_sram_we);
            if (wr & (off == O_TIM))
                timer <= merge(timer, data_sram_wdata, data_sram_we);
            else if (t_en)
                timer <= timer + 32'd1;
            if (wr & (off == O_TCTL) & data_sram_we[0]) begin
                t_en     <= data_sram_wdata[0];
                t_irq_en <= data_sram_wdata[1];
            end
            if (pend_set)
                pend <= 1'b1;
            else if (wr & (off == O_TCTL) & data_sram_we[0] & data_sram_wdata[2])
                pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            for (int i = 0; i < UART_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= data_sram_wdata[7:0];
                wp      <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            if (push_ok & ~pop)
                cnt <= cnt + 1'b1;
            else if (~push_ok & pop)
                cnt <= cnt - 1'b1;
            if (push_req & full & ~pop)
                ovf <= 1'b1;
            else if (wr & (off == O_US) & data_sram_we[0] & data_sram_wdata[2])
                ovf <= 1'b0;
        end
    end
endmodule
